mode_speed_ctrl: RTL
====================

Name: mode_speed_ctrl

Overview:
- Front-end control stage for the decorative LED board.
- Debounces the MODE push button and cycles the 2-bit mode code.
- Synchronises the two speed switches and generates the selected LED step tick from the 50 MHz board clock.
- mode, speed_sel and tick feed the LED pattern engine and the 7-segment status decoder directly.

Parameters:
- CLK_HZ, 50000000, input clock frequency; must be divisible by 4.
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required to accept a button level change; must be ≥2.

Ports:
- clk  input  1  board clock (CLK_HZ).
- rst_n  input  1  asynchronous active-low reset.
- btn_mode_n  input  1  raw MODE push button, active-low, asynchronous to clk.
- clk_sw_1  input  1  raw speed switch 1, asynchronous.
- clk_sw_2  input  1  raw speed switch 2, asynchronous.
- mode  output  2  00 none, 01 rule 1, 10 rule 2, 11 automatic.
- speed_sel  output  2  synchronised {clk_sw_1, clk_sw_2}.
- tick  output  1  one-cycle step enable at the selected rate.

Behaviour:
- **Reset.** rst_n low asynchronously forces all state to:
  - mode=00, tick=0, speed_sel=00;
  - button synchroniser flops=1, debounced button=1 (released);
  - switch synchroniser flops=0;
  - debounce counter=0, divider counter=0.
- **Synchronisers.** Each raw input passes through a 2-flop synchroniser. speed_sel equals the second-stage switch flops, so it follows a switch change 2 clk edges later.
- **Debounce.**
  - Counter clears whenever synchronised button == debounced button.
  - Otherwise the counter increments each cycle.
  - When the counter == DEBOUNCE_CYCLES-1 and the levels still differ: debounced <= synchronised, counter <= 0.
  - A glitch shorter than DEBOUNCE_CYCLES cycles is ignored.
- **Mode advance.**
  - On the same edge where debounced goes 1->0 (press), mode <= mode+1 modulo 4 (11 wraps to 00).
  - Release (0->1) does nothing.
  - Holding the button yields exactly one increment.
  - Total latency from a clean press to the mode change: 2 + DEBOUNCE_CYCLES edges.
- **Tick period N from speed_sel:**
  - 01 -> CLK_HZ (1 Hz)
  - 10 -> CLK_HZ/2 (2 Hz)
  - 11 -> CLK_HZ/4 (4 Hz)
  - 00 -> full speed
- **Divider (speed_sel ≠ 00).**
  - Counter runs 0..N-1 and wraps.
  - tick is registered: it is 1 in the cycle after the counter held N-1, else 0.
  - Exactly one tick per N cycles.
- **Full speed (speed_sel 00).** tick=1 every cycle; divider held at 0.
- **Speed change.** Any change of speed_sel clears the divider to 0 and forces tick=0 that cycle. The first tick at the new rate occurs N cycles after the change. No partial or double ticks across a change.
- **Simultaneous events.** A button press and a speed change in the same cycle are independent; both take effect.
- **Reset mid-count.** All counters abort immediately; no tick or mode change is emitted during or on exit from reset.

Test Plan:
Bench uses CLK_HZ=16, DEBOUNCE_CYCLES=4.
1. Reset: hold rst_n=0 with button pressed and switches=11 -> mode=00, tick=0, speed_sel=00. Release reset -> speed_sel=11 after 2 edges, and no mode change until 4 further stable cycles.
2. Mode cycling: 5 clean presses, each held 10 cycles and released 10 cycles -> mode sequence 01,10,11,00,01. Each change lands 6 edges after the press; holding 50 cycles gives a single increment.
3. Bounce rejection: button low 3 cycles, high 1, low 3, then high -> mode unchanged. Low for 4+ stable cycles -> exactly one increment.
4. Rates: switches 01 -> tick every 16 cycles; 10 -> every 8; 11 -> every 4; 00 -> tick constantly 1. Check pulse width = 1 cycle for the first three.
5. Speed change mid-period: at 11, change to 01 when the divider = 2 -> no tick for 16 cycles after speed_sel changes, then periodic at 16.
6. Async reset mid-operation: assert rst_n for 1 cycle during debounce count=2 and divider=7 -> all outputs return to reset values immediately. Counts restart from 0 on release; no spurious tick or mode increment.

Source files
------------

// File: rtl/mode_speed_ctrl.sv
// Front-end control for the LED board: debounces the MODE button into a 2-bit mode code,
// synchronises the speed switches and divides the board clock into the LED step tick.
module mode_speed_ctrl #(
  parameter int unsigned CLK_HZ          = 50000000,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_mode_n,
  input  logic       clk_sw_1,
  input  logic       clk_sw_2,
  output logic [1:0] mode,
  output logic [1:0] speed_sel,
  output logic       tick
);

  localparam int unsigned DivW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int unsigned DbW  = $clog2(DEBOUNCE_CYCLES);

  localparam logic [DivW-1:0] LastHz1 = DivW'(CLK_HZ - 1);
  localparam logic [DivW-1:0] LastHz2 = DivW'(CLK_HZ / 2 - 1);
  localparam logic [DivW-1:0] LastHz4 = DivW'(CLK_HZ / 4 - 1);
  localparam logic [DbW-1:0]  DbLast  = DbW'(DEBOUNCE_CYCLES - 1);

  // Two-flop synchronisers
  logic       btn_meta_q, btn_sync_q;
  logic [1:0] sw_meta_q, sw_sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_meta_q <= 1'b1;
      btn_sync_q <= 1'b1;
      sw_meta_q  <= 2'b00;
      sw_sync_q  <= 2'b00;
    end else begin
      btn_meta_q <= btn_mode_n;
      btn_sync_q <= btn_meta_q;
      sw_meta_q  <= {clk_sw_1, clk_sw_2};
      sw_sync_q  <= sw_meta_q;
    end
  end

  // Debounce and mode advance
  logic           btn_db_q, btn_db_d;
  logic [DbW-1:0] db_cnt_q, db_cnt_d;
  logic [1:0]     mode_q, mode_d;

  always_comb begin
    btn_db_d = btn_db_q;
    db_cnt_d = '0;
    if (btn_sync_q != btn_db_q) begin
      if (db_cnt_q == DbLast) begin
        btn_db_d = btn_sync_q;
      end else begin
        db_cnt_d = db_cnt_q + DbW'(1);
      end
    end
  end

  always_comb begin
    mode_d = mode_q;
    // Only the accepted press edge advances; release and hold do nothing.
    if (btn_db_q && !btn_db_d) begin
      mode_d = mode_q + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_db_q <= 1'b1;
      db_cnt_q <= '0;
      mode_q   <= 2'b00;
    end else begin
      btn_db_q <= btn_db_d;
      db_cnt_q <= db_cnt_d;
      mode_q   <= mode_d;
    end
  end

  // Tick divider
  logic [DivW-1:0] div_q, div_d;
  logic [DivW-1:0] div_last;
  logic            tick_q, tick_d;
  logic            run_q;
  logic            speed_change;

  // speed_sel is about to take a new value on this edge.
  assign speed_change = (sw_meta_q != sw_sync_q);

  always_comb begin
    case (sw_sync_q)
      2'b01:   div_last = LastHz1;
      2'b10:   div_last = LastHz2;
      2'b11:   div_last = LastHz4;
      default: div_last = '0;
    endcase
  end

  always_comb begin
    div_d  = div_q + DivW'(1);
    tick_d = 1'b0;
    // run_q keeps the first cycle out of reset tick-free even at full speed.
    if (!run_q || speed_change) begin
      div_d  = '0;
      tick_d = 1'b0;
    end else if (sw_sync_q == 2'b00) begin
      div_d  = '0;
      tick_d = 1'b1;
    end else if (div_q == div_last) begin
      div_d  = '0;
      tick_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q  <= '0;
      tick_q <= 1'b0;
      run_q  <= 1'b0;
    end else begin
      div_q  <= div_d;
      tick_q <= tick_d;
      run_q  <= 1'b1;
    end
  end

  assign mode      = mode_q;
  assign speed_sel = sw_sync_q;
  assign tick      = tick_q;

endmodule
